register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_WIDTH, 32, register width in bits.
REQ-002 Parameter NUM_REGS, 32, register count, 2..256; address width AW = $clog2(NUM_REGS).
REQ-003 Parameter ZERO_REG0, 1, when 1 register 0 is hardwired to zero.
REQ-004 clk  input  1  rising-edge clock, sole clock of the block.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 ready  output  1  high when initialisation is complete and ports are live.
REQ-007 we_a / wa_a / wd_a  input  1 / AW / DATA_WIDTH  write port A: enable, address, data.
REQ-008 we_b / wa_b / wd_b  input  1 / AW / DATA_WIDTH  write port B: enable, address, data.
REQ-009 ra1, ra2  input  AW each  read port 1 and 2 addresses.
REQ-010 rd1, rd2  output  DATA_WIDTH each  read port 1 and 2 data, combinational from state and inputs.

Function
REQ-011 FSM SHALL have two states: INIT and RUN.
REQ-012 INIT: one register per cycle SHALL be cleared to 0, indexed by counter init_cnt starting at 0.
REQ-013 INIT SHALL go to RUN on the edge after clearing register NUM_REGS-1, so ready rises exactly NUM_REGS cycles after the first cycle with rst low.
REQ-014 In INIT, ready SHALL be 0, both write ports SHALL be ignored, and rd1/rd2 SHALL read 0.
REQ-015 In RUN, ready SHALL be 1 and the FSM SHALL stay in RUN until rst.
REQ-016 RUN, we_x=1: rf[wa_x] SHALL update to wd_x on the next rising edge.
REQ-017 Both ports enabled with wa_a == wa_b: port B data SHALL be written and port A data dropped.
REQ-018 Both ports enabled with different addresses: both writes SHALL complete in the same cycle.
REQ-019 With ZERO_REG0=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0 in every state.
REQ-020 Address >= NUM_REGS (non-power-of-two NUM_REGS): writes SHALL be ignored and reads SHALL return 0.
REQ-021 Reads SHALL be asynchronous: rd1 = rf[ra1] and rd2 = rf[ra2], subject to REQ-014, REQ-019, REQ-020 and REQ-026.
REQ-022 Write data SHALL be stored at full DATA_WIDTH with no truncation or extension.

Reset
REQ-023 rst=1 on a rising edge SHALL set state=INIT, init_cnt=0 and ready=0.
REQ-024 While rst is held, the block SHALL remain in INIT with init_cnt=0 and SHALL clear no registers beyond register 0.
REQ-025 rst asserted mid-INIT or mid-RUN SHALL restart the full sweep from register 0, with no write from that cycle taking effect.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: in RUN, a read whose address matches an enabled, valid (REQ-019/REQ-020) write address in the same cycle SHALL return that write data combinationally; on a double match, port B data SHALL be returned.
REQ-027 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value, so a same-cycle write is visible only from the next cycle.

Verification
REQ-028 Reset sequence: rst=1 for 3 cycles, then 0 -> ready=0 for exactly 32 cycles and 1 on cycle 33; all 32 registers then read 0.
REQ-029 Dual write: we_a=1 with wa_a=5, wd_a=0xDEADBEEF, and we_b=1 with wa_b=9, wd_b=0x12345678 -> next cycle, ra1=5 reads 0xDEADBEEF and ra2=9 reads 0x12345678.
REQ-030 Collision: both ports write address 7, wd_a=0x1111, wd_b=0x2222 -> rd1 for ra1=7 reads 0x2222.
REQ-031 Zero register: we_a=1, wa_a=0, wd_a=0xFFFFFFFF -> ra1=0 reads 0, with and without REGFILE_BYPASS_EN.
REQ-032 Bypass: write address 3, 0xCAFE, while ra1=3 in the same cycle -> rd1=0xCAFE with REGFILE_BYPASS_EN defined, rd1 = prior value (0) without it.
REQ-033 Mid-run reset: load 0xAAAA into register 12, pulse rst for 1 cycle, issue a write to address 12 during INIT -> ready low for 32 cycles, then register 12 reads 0.

Source files
------------

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//   Multi-ported register file: two write ports (A, B) and two asynchronous
//   read ports. After reset an INIT sweep clears one register per cycle. The
//   ports go live (ready=1) only once every register holds zero.
//
// Parameters
//   DATA_WIDTH  register width in bits
//   NUM_REGS    register count (2..256), AW = $clog2(NUM_REGS)
//   ZERO_REG0   1: register 0 always reads 0 and ignores writes
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active-high
//   ready            1 when the clear sweep is done and the ports are live
//   we_a/wa_a/wd_a   write port A: enable, address, data
//   we_b/wa_b/wd_b   write port B: enable, address, data (B wins a collision)
//   ra1/rd1, ra2/rd2 read ports: address in, combinational data out
//
// Build option
//   REGFILE_BYPASS_EN  defined: a read that hits a same-cycle write returns
//                      the write data (port B first). Undefined: reads return
//                      the stored value, so a write shows up one cycle later.
// -----------------------------------------------------------------------------
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter bit ZERO_REG0  = 1'b1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  we_a,
  input  logic [AW-1:0]         wa_a,
  input  logic [DATA_WIDTH-1:0] wd_a,
  input  logic                  we_b,
  input  logic [AW-1:0]         wa_b,
  input  logic [DATA_WIDTH-1:0] wd_b,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0]   rf_q [NUM_REGS];
  logic                    wr_a, wr_b;

  // An address is usable if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    addr_ok = (int'(addr) < NUM_REGS) && !(ZERO_REG0 && (addr == '0));
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM: INIT sweeps init_cnt over every register, then RUN until rst.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign ready = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Write path. On an address collision port A is suppressed so B's data lands.
  // ---------------------------------------------------------------------------
  assign wr_a = (state_q == ST_RUN) && we_a && addr_ok(wa_a)
                && !(we_b && (wa_b == wa_a));
  assign wr_b = (state_q == ST_RUN) && we_b && addr_ok(wa_b);

  // NOTE: the storage array has no reset branch; the INIT sweep zeroes it, so
  // it can map onto plain storage without a reset net on every bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        rf_q[init_cnt_q] <= '0;
      end else begin
        if (wr_a) rf_q[wa_a] <= wd_a;
        if (wr_b) rf_q[wa_b] <= wd_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: zero while INIT or for unusable addresses.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state_q == ST_RUN) begin
      if (addr_ok(ra1)) rd1 = rf_q[ra1];
      if (addr_ok(ra2)) rd2 = rf_q[ra2];
`ifdef REGFILE_BYPASS_EN
      // wr_a/wr_b already exclude invalid addresses; B is applied last so it
      // wins a double match, just as it wins the write itself.
      if (wr_a && (wa_a == ra1)) rd1 = wd_a;
      if (wr_b && (wa_b == ra1)) rd1 = wd_b;
      if (wr_a && (wa_a == ra2)) rd2 = wd_a;
      if (wr_b && (wa_b == ra2)) rd2 = wd_b;
`endif
    end
  end

endmodule
